// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side drain logic.
// The occupancy encoding equals the number of buffered words.
package fifo_rd_pkg;

  localparam int DATASIZE_DEF  = 8;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_ONE   = 2'd1,
    RD_TWO   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/skid buffer with its occupancy FSM.
// o_data is the head register; o_valid is registered alongside the state.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [DATASIZE-1:0] i_push_data,
  input  logic                i_pop,
  input  logic                i_flush,
  output logic                o_valid,
  output logic [DATASIZE-1:0] o_data,
  output rd_state_e           o_state
);

  rd_state_e           r_state;
  logic                r_valid;
  logic [DATASIZE-1:0] r_head;
  logic [DATASIZE-1:0] r_skid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RD_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (i_flush) begin
      // Popped words are dropped; the data registers keep stale contents.
      r_state <= RD_EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        RD_EMPTY: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_state <= RD_ONE;
            r_valid <= 1'b1;
          end
        end
        RD_ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_skid  <= i_push_data;
            r_state <= RD_TWO;
          end else if (i_pop) begin
            r_state <= RD_EMPTY;
            r_valid <= 1'b0;
          end
        end
        RD_TWO: begin
          if (i_pop) begin
            r_head  <= r_skid;
            r_state <= RD_ONE;
          end
        end
        default: begin
          r_state <= RD_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_read_drain.sv
// Read-side FIFO consumer: pops first-word-fall-through data into a skid buffer.
// Define FIFO_RD_WORDCNT_EN to enable the saturating delivered-word counter.
module fifo_read_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE  = DATASIZE_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 rclk,
  input  logic                 rreset,
  input  logic                 rempty,
  input  logic [DATASIZE-1:0]  rdata,
  output logic                 rinc,
  input  logic                 ren,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [DATASIZE-1:0]  out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] rd_count
);

  rd_state_e w_state;
  logic      w_deliver;

  // Never pop into a full buffer unless flushing, and never while reset is held.
  assign rinc      = !rreset && !rempty && ((ren && (w_state != RD_TWO)) || flush);
  assign w_deliver = out_valid && out_ready;

  rd_skid_buf #(
    .DATASIZE(DATASIZE)
  ) u_skid (
    .i_clk      (rclk),
    .i_rst      (rreset),
    .i_push     (rinc),
    .i_push_data(rdata),
    .i_pop      (w_deliver),
    .i_flush    (flush),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_state    (w_state)
  );

`ifdef FIFO_RD_WORDCNT_EN
  logic [CNT_WIDTH-1:0] r_rd_count;

  // A handshake during flush still counts; only reset clears the count.
  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_rd_count <= '0;
    end else if (w_deliver && (r_rd_count != {CNT_WIDTH{1'b1}})) begin
      r_rd_count <= r_rd_count + 1'b1;
    end
  end

  assign rd_count = r_rd_count;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// Directed and randomized bench for fifo_read_drain against a queue-based model.
module tb_fifo_read_drain;

  logic        rclk = 1'b0;
  logic        rreset;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        ren;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [15:0] rd_count;

  always #5 rclk = ~rclk;

  fifo_read_drain #(
    .DATASIZE (8),
    .CNT_WIDTH(16)
  ) dut (
    .rclk     (rclk),
    .rreset   (rreset),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .ren      (ren),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .rd_count (rd_count)
  );

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] m_cnt;
  logic        m_zero;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic step(input logic i_ren, input logic i_ready, input logic i_flush, input logic i_rst);
    logic       exp_rinc;
    logic       deliver;
    logic [7:0] w;
    @(negedge rclk);
    ren       = i_ren;
    out_ready = i_ready;
    flush     = i_flush;
    rreset    = i_rst;
    rempty    = (fifo_q.size() == 0);
    rdata     = rempty ? 8'($urandom) : fifo_q[0];
    #1;
    exp_rinc = !i_rst && !rempty && ((i_ren && exp_q.size() < 2) || i_flush);
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    else if (m_zero) chk("out_data_rst", 32'(out_data), 32'h0);
    chk("occupancy", 32'(2'(dut.w_state)), 32'(exp_q.size()));
`ifdef FIFO_RD_WORDCNT_EN
    chk("rd_count", 32'(rd_count), 32'(m_cnt));
`else
    chk("rd_count", 32'(rd_count), 32'h0);
`endif
    @(posedge rclk);
    if (i_rst) begin
      exp_q.delete();
      m_cnt  = '0;
      m_zero = 1'b1;
    end else begin
      deliver = (exp_q.size() > 0) && i_ready;
      if (deliver && m_cnt != 16'hFFFF) m_cnt++;
      w = 8'h00;
      if (exp_rinc) begin
        w      = fifo_q.pop_front();
        m_zero = 1'b0;
      end
      if (i_flush) begin
        exp_q.delete();
      end else begin
        if (deliver) void'(exp_q.pop_front());
        if (exp_rinc) exp_q.push_back(w);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rreset    = 1'b1;
    ren       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rempty    = 1'b1;
    rdata     = 8'h00;
    m_cnt     = '0;
    m_zero    = 1'b1;
    repeat (2) @(posedge rclk);

    // Idle after reset: empty FIFO, drain enabled.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Full-rate stream of three words.
    load(8'h11); load(8'h22); load(8'h33);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: only two pops, head held, then drain in order.
    load(8'h41); load(8'h42); load(8'h43); load(8'h44);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Alternating ready with continuous data.
    for (int i = 0; i < 10; i++) load(8'($urandom));
    for (int i = 0; i < 16; i++) step(1'b1, 1'(i % 2 == 0), 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Flush from TWO with three more words waiting in the FIFO.
    load(8'hAA); load(8'hBB);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    load(8'hC1); load(8'hC2); load(8'hC3);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
    load(8'hD1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Reset while holding two words, then count five handshakes.
    for (int i = 0; i < 4; i++) load(8'($urandom));
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    fifo_q.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) load(8'($urandom));
    repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) load(8'($urandom));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
